// File: rtl/p32_seq_ctrl.sv
// Multicycle fetch/decode/execute/writeback sequencer, one instruction in flight.
// Latency: 4 cycles from run to the register write when imem_ack and alu_done arrive at once.
// Backpressure: FETCH waits for imem_ack, EXEC waits for alu_done (bounded), a WB store waits for dmem_ack.
module p32_seq_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          PC_STEP      = 4,
    parameter logic [7:0]  HALT_OP      = 8'hFF,
    parameter int          EXEC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    output logic        alu_start,
    output logic [7:0]  alu_opcode,
    output logic        alu_isfloat,
    output logic        alu_src,
    output logic [15:0] alu_imm,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        dmem_req,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        halted,
    output logic        err,
    output logic [31:0] retired
);

    localparam int CW = $clog2(EXEC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        DST_RF   = 2'b00,
        DST_MEM  = 2'b01,
        DST_PC   = 2'b10,
        DST_NONE = 2'b11
    } dst_t;

    state_t        state_q;
    state_t        state_d;
    logic [31:0]   pc_q;
    logic [31:0]   ir_q;
    logic [31:0]   result_q;
    logic [31:0]   retired_q;
    logic [CW-1:0] exec_cnt_q;

    // IR: [31:28] opcode high nibble, [27] isfloat, [26] src, [25:24] dst,
    // [23:20] rd, [19:16] rs, [15:0] imm. rd doubles as the opcode low nibble.
    logic [3:0]  ir_rd;
    logic [3:0]  ir_rs;
    logic [7:0]  ir_opcode;
    dst_t        ir_dst;
    logic        timeout_hit;
    logic        wb_exit;

    assign ir_rd       = ir_q[23:20];
    assign ir_rs       = ir_q[19:16];
    assign ir_opcode   = {ir_q[31:28], ir_q[23:20]};
    assign ir_dst      = dst_t'(ir_q[25:24]);
    assign timeout_hit = (exec_cnt_q == CW'(EXEC_TIMEOUT));
    assign wb_exit     = (state_q == S_WB) && ((ir_dst != DST_MEM) || dmem_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = (ir_opcode == HALT_OP) ? S_HALT : S_EXEC;
            S_EXEC: begin
                // done on the final allowed cycle still completes normally
                if (alu_done)         state_d = S_WB;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_WB:     if (wb_exit) state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        alu_start = 1'b0;
        rf_we     = 1'b0;
        dmem_req  = 1'b0;
        halted    = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_FETCH: imem_req  = 1'b1;
            S_EXEC:  alu_start = (exec_cnt_q == CW'(1));
            S_WB: begin
                rf_we    = (ir_dst == DST_RF);
                dmem_req = (ir_dst == DST_MEM);
            end
            S_HALT:  halted = 1'b1;
            S_ERR:   err    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            result_q   <= '0;
            retired_q  <= '0;
            exec_cnt_q <= '0;
        end else begin
            if (state_q == S_FETCH && imem_ack) begin
                ir_q <= imem_rdata;
                pc_q <= pc_q + 32'(PC_STEP);
            end
            if (state_q == S_DECODE) begin
                exec_cnt_q <= CW'(1);
            end
            if (state_q == S_EXEC) begin
                if (alu_done) result_q   <= alu_result;
                else          exec_cnt_q <= exec_cnt_q + CW'(1);
            end
            if (wb_exit) begin
                retired_q <= retired_q + 32'd1;
                if (ir_dst == DST_PC) pc_q <= result_q;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign state       = state_q;
    assign retired     = retired_q;
    assign rf_raddr_a  = ir_rd;
    assign rf_raddr_b  = ir_rs;
    assign alu_opcode  = ir_opcode;
    assign alu_isfloat = ir_q[27];
    assign alu_src     = ir_q[26];
    assign alu_imm     = ir_q[15:0];
    assign rf_waddr    = ir_rd;
    assign rf_wdata    = result_q;
    assign dmem_wdata  = result_q;

endmodule

// File: tb/tb_p32_seq_ctrl.sv
// Bench for p32_seq_ctrl: directed cases plus random instruction streams,
// each instruction checked against a transaction-level model of pc/retired/handshakes.
module tb_p32_seq_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic        alu_start;
    logic [7:0]  alu_opcode;
    logic        alu_isfloat;
    logic        alu_src;
    logic [15:0] alu_imm;
    logic        alu_done;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        dmem_req;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        halted;
    logic        err;
    logic [31:0] retired;

    p32_seq_ctrl #(.EXEC_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_isfloat(alu_isfloat),
        .alu_src(alu_src), .alu_imm(alu_imm), .alu_done(alu_done), .alu_result(alu_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dmem_req(dmem_req), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .pc(pc), .state(state), .halted(halted), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          wb_cyc = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    // One instruction end to end. fd/ad/dd: cycles the memory, ALU and store port stall.
    // ad >= TO means the ALU never answers.
    task automatic do_instr(input logic [3:0] op_hi, input logic isf, input logic src,
                            input logic [1:0] dst, input logic [3:0] rd, input logic [3:0] rs,
                            input logic [15:0] imm, input int fd, input int ad, input int dd,
                            input logic [31:0] res, input logic rand_run);
        logic [31:0] instr;
        logic [7:0]  op;
        instr = {op_hi, isf, src, dst, rd, rs, imm};
        op    = {op_hi, rd};
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < fd; i++) @(negedge clk);
        if (fd > 0) chk("fetch_hold", imem_req, 1);
        imem_ack = 1'b1; imem_rdata = instr;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        if (rand_run) run = 1'($urandom_range(0, 1));
        exp_pc = exp_pc + 32'd4;
        chk("dec_state", state, 2);
        chk("raddr_a", rf_raddr_a, rd);
        chk("raddr_b", rf_raddr_b, rs);
        chk("pc_inc", pc, exp_pc);
        @(negedge clk);
        if (op == 8'hFF) begin
            chk("halt_state", state, 5);
            chk("halted", halted, 1);
            chk("halt_ret", retired, exp_ret);
            chk("halt_noreq", imem_req, 0);
            return;
        end
        for (int k = 1; k <= TO; k++) begin
            if (k == 1) begin
                chk("exec_state", state, 3);
                chk("alu_start", alu_start, 1);
                chk("alu_opcode", alu_opcode, op);
                chk("alu_isfloat", alu_isfloat, isf);
                chk("alu_src", alu_src, src);
                chk("alu_imm", alu_imm, imm);
            end
            if (k == 2) chk("alu_start_once", alu_start, 0);
            if (k == ad + 1) begin
                alu_done = 1'b1; alu_result = res;
                @(negedge clk);
                alu_done = 1'b0; alu_result = $urandom;
                break;
            end
            @(negedge clk);
            if (k == TO) begin
                chk("err", err, 1);
                chk("err_state", state, 6);
                chk("err_noreq", imem_req, 0);
                return;
            end
        end
        chk("wb_state", state, 4);
        chk("wb_noerr", err, 0);
        case (dst)
            2'b00: begin
                chk("rf_we", rf_we, 1);
                chk("rf_waddr", rf_waddr, rd);
                chk("rf_wdata", rf_wdata, res);
                wb_cyc = cyc;
                @(negedge clk);
                chk("rf_we_pulse", rf_we, 0);
            end
            2'b01: begin
                chk("st_no_rfwe", rf_we, 0);
                for (int i = 0; i < dd; i++) begin
                    chk("dmem_hold", dmem_req, 1);
                    @(negedge clk);
                end
                chk("dmem_req", dmem_req, 1);
                chk("dmem_wdata", dmem_wdata, res);
                chk("st_ret_wait", retired, exp_ret);
                dmem_ack = 1'b1;
                @(negedge clk);
                dmem_ack = 1'b0;
                chk("dmem_drop", dmem_req, 0);
            end
            2'b10: begin
                @(negedge clk);
                exp_pc = res;
            end
            default: begin
                chk("nop_we", rf_we, 0);
                chk("nop_dmem", dmem_req, 0);
                @(negedge clk);
            end
        endcase
        exp_ret = exp_ret + 32'd1;
        chk("retired", retired, exp_ret);
        chk("back_to_fetch", state, 1);
        chk("pc_after", pc, exp_pc);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ret", retired, 0);
        chk("rst_flags", {halted, err, imem_req, rf_we, dmem_req, alu_start}, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0; exp_ret = 32'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] oh;
        logic [3:0] rdr;
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        alu_done = 1'b0; alu_result = '0; dmem_ack = 1'b0;
        exp_pc = 32'h0; exp_ret = 32'h0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ret", retired, 0);
        chk("rst_outs", {halted, err, imem_req, rf_we, dmem_req, alu_start, rf_raddr_a, alu_opcode}, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("idle_hold", state, 0);

        // latency case 0x1000_5003
        run = 1'b1;
        begin
            int c0;
            c0 = cyc;
            do_instr(4'h1, 0, 0, 2'b00, 4'h0, 4'h0, 16'h5003, 0, 0, 0, 32'hCAFE_0001, 0);
            chk("latency", 32'(wb_cyc - c0), 4);
        end
        // 0x2430_0007: immediate operand
        do_instr(4'h2, 0, 1, 2'b00, 4'h3, 4'h0, 16'h0007, 0, 0, 0, 32'h1234_5678, 0);
        // branch, then a branch to the top of the address space to exercise the wrap
        do_instr(4'h3, 0, 0, 2'b10, 4'h1, 4'h2, 16'h0000, 1, 2, 0, 32'h0000_0100, 0);
        do_instr(4'h3, 1, 0, 2'b10, 4'h1, 4'h2, 16'h0000, 0, 0, 0, 32'hFFFF_FFFC, 0);
        do_instr(4'h4, 0, 0, 2'b11, 4'h5, 4'h6, 16'h00AA, 0, 1, 0, 32'h0, 0);
        // store stalled for 5 cycles
        do_instr(4'h5, 0, 0, 2'b01, 4'h7, 4'h8, 16'h0001, 0, 0, 5, 32'hDEAD_BEEF, 0);

        for (int n = 0; n < 40; n++) begin
            oh  = 4'($urandom);
            rdr = 4'($urandom);
            if ({oh, rdr} == 8'hFF) rdr = 4'h0;
            do_instr(oh, 1'($urandom), 1'($urandom), 2'($urandom), rdr, 4'($urandom),
                     16'($urandom), $urandom_range(0, 3), $urandom_range(0, 4),
                     $urandom_range(0, 3), $urandom, 1);
        end
        run = 1'b1;

        // done on the last allowed cycle wins over the timeout
        do_instr(4'h6, 0, 0, 2'b00, 4'h9, 4'h1, 16'h0, 0, TO - 1, 0, 32'h0BAD_F00D, 0);
        // halt
        do_instr(4'hF, 0, 0, 2'b00, 4'hF, 4'h0, 16'h0, 0, 0, 0, 32'h0, 0);
        repeat (3) @(negedge clk);
        chk("halt_sticky", {halted, imem_req}, 2'b10);
        chk("halt_ret_keep", retired, exp_ret);

        reset_dut();
        do_instr(4'h7, 0, 0, 2'b00, 4'h2, 4'h3, 16'h0, 0, 0, 0, 32'h77, 0);
        // ALU never answers
        do_instr(4'h8, 0, 0, 2'b00, 4'h2, 4'h3, 16'h0, 0, TO, 0, 32'h0, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", {err, halted, imem_req}, 3'b100);

        // reset while a fetch is outstanding
        reset_dut();
        do_instr(4'h1, 0, 0, 2'b11, 4'h0, 4'h0, 16'h0, 0, 0, 0, 32'h0, 0);
        chk("pre_rst_req", imem_req, 1);
        chk("pre_rst_pc", pc, 4);
        #2 rst = 1'b1;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_pc", pc, 0);
        chk("async_state", state, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
